// File: rtl/pixel_distributor_if.sv
// Engine pixel-request bus between the distributor (master) and the engine array (slave).
interface pixel_distributor_if #(
  parameter int PIXEL_DATA_WIDTH = 10,
  parameter int NUM_ENGINES      = 4
);
  logic                                    start;
  logic [NUM_ENGINES-1:0]                  engine_ready;
  logic [NUM_ENGINES*PIXEL_DATA_WIDTH-1:0] x0_out;
  logic [NUM_ENGINES*PIXEL_DATA_WIDTH-1:0] y0_out;
  logic [NUM_ENGINES-1:0]                  pixel_valid;
  logic                                    busy;
  logic                                    frame_done;

  // Per slot i: pixel_valid[i] says x0/y0 slot i holds an unconsumed pixel; engine_ready[i]
  // high while pixel_valid[i] is high means the engine has latched it, and the slot moves to
  // the next pixel one clock later. engine_ready on an invalid slot is ignored.
  modport master (
    input  start, engine_ready,
    output x0_out, y0_out, pixel_valid, busy, frame_done
  );

  modport slave (
    output start, engine_ready,
    input  x0_out, y0_out, pixel_valid, busy, frame_done
  );
endinterface

// File: rtl/pixel_distributor.sv
// Raster-order pixel distributor feeding NUM_ENGINES engines, round-robin on engine_ready.
// Optional macro DISTRIBUTOR_PAUSE_EN adds a `pause` input that freezes loads and grants.
module pixel_distributor #(
  parameter int PIXEL_DATA_WIDTH = 10,
  parameter int NUM_ENGINES      = 4,
  parameter int SCREEN_WIDTH     = 640,
  parameter int SCREEN_HEIGHT    = 480
) (
  input  logic                      clk,
  input  logic                      reset,
`ifdef DISTRIBUTOR_PAUSE_EN
  input  logic                      pause,
`endif
  pixel_distributor_if.master       bus,
  output logic [1:0]                state_dbg
);

  localparam int W     = PIXEL_DATA_WIDTH;
  localparam int N     = NUM_ENGINES;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0]     X_LAST   = W'(SCREEN_WIDTH - 1);
  localparam logic [W-1:0]     Y_LAST   = W'(SCREEN_HEIGHT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t           state;
  logic [W-1:0]     cx, cy, nx, ny;
  logic             exhausted;
  logic             last_pixel;
  logic             active;
  logic [IDX_W-1:0] rr, prime_idx, grant_idx, scan_idx, rr_next;
  logic             grant_found;
  logic [N-1:0]     holdoff, eligible;
  logic [N*W-1:0]   x0_q, y0_q;
  logic [N-1:0]     valid_q;
  logic             busy_q, frame_done_q;

`ifdef DISTRIBUTOR_PAUSE_EN
  assign active = ~pause;
`else
  assign active = 1'b1;
`endif

  assign bus.x0_out      = x0_q;
  assign bus.y0_out      = y0_q;
  assign bus.pixel_valid = valid_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = frame_done_q;
  assign state_dbg       = state;

  assign last_pixel = (cx == X_LAST) && (cy == Y_LAST);

  always_comb begin
    nx = cx + 1'b1;
    ny = cy;
    if (cx == X_LAST) begin
      nx = '0;
      ny = (cy == Y_LAST) ? '0 : cy + 1'b1;
    end
  end

  // holdoff masks a ready that is still high from the coordinate just replaced
  assign eligible = valid_q & bus.engine_ready & ~holdoff;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = rr;
    for (int k = 0; k < N; k++) begin
      if (!grant_found && eligible[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
      scan_idx = (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
    end
    rr_next = (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cx           <= '0;
      cy           <= '0;
      exhausted    <= 1'b0;
      rr           <= '0;
      prime_idx    <= '0;
      holdoff      <= '0;
      x0_q         <= '0;
      y0_q         <= '0;
      valid_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      holdoff      <= '0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            cx        <= '0;
            cy        <= '0;
            exhausted <= 1'b0;
            prime_idx <= '0;
            busy_q    <= 1'b1;
            state     <= PRIME;
          end
        end
        PRIME: begin
          if (active) begin
            for (int i = 0; i < N; i++) begin
              if (IDX_W'(i) == prime_idx) begin
                x0_q[i*W +: W] <= cx;
                y0_q[i*W +: W] <= cy;
                valid_q[i]     <= 1'b1;
              end
            end
            cx <= nx;
            cy <= ny;
            if (last_pixel) exhausted <= 1'b1;
            // a screen smaller than the engine count stops priming early
            if (last_pixel || prime_idx == IDX_LAST) state <= RUN;
            else prime_idx <= prime_idx + 1'b1;
          end
        end
        RUN: begin
          if (active) begin
            if (exhausted && valid_q == '0) begin
              frame_done_q <= 1'b1;
              busy_q       <= 1'b0;
              state        <= IDLE;
            end else if (grant_found) begin
              rr <= rr_next;
              for (int i = 0; i < N; i++) begin
                if (IDX_W'(i) == grant_idx) begin
                  holdoff[i] <= 1'b1;
                  if (exhausted) begin
                    valid_q[i] <= 1'b0;
                  end else begin
                    x0_q[i*W +: W] <= cx;
                    y0_q[i*W +: W] <= cy;
                  end
                end
              end
              if (!exhausted) begin
                cx <= nx;
                cy <= ny;
                if (last_pixel) exhausted <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_distributor.sv
// Bench for pixel_distributor: three instances (640x480, 4x2, 3x1) with a load scoreboard.
module tb_pixel_distributor;
  localparam int W = 10;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

`ifdef DISTRIBUTOR_PAUSE_EN
  logic pause = 1'b0;
`endif

  pixel_distributor_if #(.PIXEL_DATA_WIDTH(W), .NUM_ENGINES(N)) bus_a ();
  pixel_distributor_if #(.PIXEL_DATA_WIDTH(W), .NUM_ENGINES(N)) bus_b ();
  pixel_distributor_if #(.PIXEL_DATA_WIDTH(W), .NUM_ENGINES(N)) bus_c ();
  logic [1:0] st_a, st_b, st_c;

  pixel_distributor #(.PIXEL_DATA_WIDTH(W), .NUM_ENGINES(N),
                      .SCREEN_WIDTH(640), .SCREEN_HEIGHT(480)) dut_a (
    .clk(clk), .reset(reset),
`ifdef DISTRIBUTOR_PAUSE_EN
    .pause(pause),
`endif
    .bus(bus_a), .state_dbg(st_a));

  pixel_distributor #(.PIXEL_DATA_WIDTH(W), .NUM_ENGINES(N),
                      .SCREEN_WIDTH(4), .SCREEN_HEIGHT(2)) dut_b (
    .clk(clk), .reset(reset),
`ifdef DISTRIBUTOR_PAUSE_EN
    .pause(pause),
`endif
    .bus(bus_b), .state_dbg(st_b));

  pixel_distributor #(.PIXEL_DATA_WIDTH(W), .NUM_ENGINES(N),
                      .SCREEN_WIDTH(3), .SCREEN_HEIGHT(1)) dut_c (
    .clk(clk), .reset(reset),
`ifdef DISTRIBUTOR_PAUSE_EN
    .pause(pause),
`endif
    .bus(bus_c), .state_dbg(st_c));

  int checks = 0;
  int errors = 0;

  // Scoreboard: one entry per expected slot load, {slot, x, y}
  logic [23:0] exp_a[$];
  logic [23:0] exp_b[$];
  logic [23:0] exp_c[$];
  logic [N-1:0]   pv [3] = '{default: '0};
  logic [N*W-1:0] px [3] = '{default: '0};
  logic [N*W-1:0] py [3] = '{default: '0};
  int             fd_cnt [3] = '{default: 0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [W-1:0] slot(input logic [N*W-1:0] v, input int i);
    return v[i*W +: W];
  endfunction

  function automatic void push(input int d, input int s, input int x, input int y);
    logic [23:0] item;
    item = {4'(s), 10'(x), 10'(y)};
    case (d)
      0:       exp_a.push_back(item);
      1:       exp_b.push_back(item);
      default: exp_c.push_back(item);
    endcase
  endfunction

  task automatic mon(input int d, input logic [N-1:0] v, input logic [N*W-1:0] x,
                     input logic [N*W-1:0] y, input logic fd, input logic en);
    logic [23:0] item, expv;
    logic        ok;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        if (v[i] && (!pv[d][i] || slot(x, i) != slot(px[d], i) || slot(y, i) != slot(py[d], i))) begin
          item = {4'(i), slot(x, i), slot(y, i)};
          ok   = 1'b0;
          expv = '0;
          case (d)
            0:       if (exp_a.size() > 0) begin ok = 1'b1; expv = exp_a.pop_front(); end
            1:       if (exp_b.size() > 0) begin ok = 1'b1; expv = exp_b.pop_front(); end
            default: if (exp_c.size() > 0) begin ok = 1'b1; expv = exp_c.pop_front(); end
          endcase
          if (ok) begin
            chk($sformatf("load_dut%0d", d), 64'(item), 64'(expv));
          end else begin
            checks++;
            errors++;
            $display("FAIL load_dut%0d: got slot %0d (%0d,%0d) expected no load", d, i,
                     slot(x, i), slot(y, i));
          end
        end
      end
      if (fd) fd_cnt[d]++;
    end
    pv[d] = v;
    px[d] = x;
    py[d] = y;
  endtask

  always @(negedge clk) begin
    mon(0, bus_a.pixel_valid, bus_a.x0_out, bus_a.y0_out, bus_a.frame_done, !reset);
    mon(1, bus_b.pixel_valid, bus_b.x0_out, bus_b.y0_out, bus_b.frame_done, !reset);
    mon(2, bus_c.pixel_valid, bus_c.x0_out, bus_c.y0_out, bus_c.frame_done, !reset);
  end

  // Driver tasks: inputs change on the falling edge, outputs are checked there too
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_valid", 64'(bus_a.pixel_valid), 64'd0);
    chk("rst_busy", 64'(bus_a.busy), 64'd0);
    chk("rst_frame_done", 64'(bus_a.frame_done), 64'd0);
    chk("rst_x0", 64'(bus_a.x0_out), 64'd0);
    chk("rst_y0", 64'(bus_a.y0_out), 64'd0);
    chk("rst_state", 64'(st_a), 64'd0);
    reset = 1'b0;
  endtask

  task automatic start_a_prime();
    for (int k = 0; k < 4; k++) push(0, k, k, 0);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    chk("prime_busy", 64'(bus_a.busy), 64'd1);
    chk("prime_valid0", 64'(bus_a.pixel_valid), 64'd0);
    for (int s = 1; s <= 4; s++) begin
      @(negedge clk);
      chk($sformatf("prime_valid%0d", s), 64'(bus_a.pixel_valid), 64'((1 << s) - 1));
    end
    chk("prime_state_run", 64'(st_a), 64'd2);
  endtask

  int cnt;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.start = 1'b0; bus_a.engine_ready = '0;
    bus_b.start = 1'b0; bus_b.engine_ready = '0;
    bus_c.start = 1'b0; bus_c.engine_ready = '0;
    repeat (2) @(negedge clk);
    do_reset();

    // Prime, then a 2-cycle ready on engine 2: one new pixel only
    start_a_prime();
    push(0, 2, 4, 0);
    bus_a.engine_ready = 4'b0100;
    repeat (2) @(negedge clk);
    bus_a.engine_ready = '0;
    repeat (3) @(negedge clk);
    chk("holdoff_x2", 64'(slot(bus_a.x0_out, 2)), 64'd4);
    chk("holdoff_y2", 64'(slot(bus_a.y0_out, 2)), 64'd0);
    chk("holdoff_valid", 64'(bus_a.pixel_valid), 64'hf);
    chk("holdoff_drained", 64'(exp_a.size()), 64'd0);

    // Reset mid-RUN aborts, then all-ready served in rr order
    do_reset();
    start_a_prime();
    for (int k = 4; k < 8; k++) push(0, k % 4, k, 0);
    bus_a.engine_ready = 4'b1111;
    repeat (4) @(negedge clk);
    bus_a.engine_ready = '0;
    repeat (3) @(negedge clk);
    chk("rr_drained", 64'(exp_a.size()), 64'd0);
    chk("rr_x3", 64'(slot(bus_a.x0_out, 3)), 64'd7);

    // Line wrap: pixels 8..643, (639,0) followed by (0,1)
    for (int k = 8; k < 644; k++) push(0, k % 4, k % 640, k / 640);
    bus_a.engine_ready = 4'b1111;
    repeat (636) @(negedge clk);
    bus_a.engine_ready = '0;
    repeat (3) @(negedge clk);
    chk("wrap_drained", 64'(exp_a.size()), 64'd0);
    chk("wrap_x0", 64'(slot(bus_a.x0_out, 0)), 64'd0);
    chk("wrap_y0", 64'(slot(bus_a.y0_out, 0)), 64'd1);

    // Full 4x2 frame with engines always ready
    for (int k = 0; k < 8; k++) push(1, k % 4, k % 4, k / 4);
    bus_b.engine_ready = 4'b1111;
    bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    cnt = 1;
    while (!bus_b.frame_done && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    chk("frame_b_latency", 64'(cnt), 64'd14);
    chk("frame_b_valid", 64'(bus_b.pixel_valid), 64'd0);
    chk("frame_b_busy", 64'(bus_b.busy), 64'd0);
    chk("frame_b_state", 64'(st_b), 64'd0);
    chk("frame_b_drained", 64'(exp_b.size()), 64'd0);
    for (int k = 0; k < 4; k++) push(1, k, k, 0);
    bus_b.engine_ready = '0;
    bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    chk("restart_b_busy", 64'(bus_b.busy), 64'd1);
    chk("restart_b_fd_low", 64'(bus_b.frame_done), 64'd0);
    repeat (6) @(negedge clk);
    chk("restart_b_drained", 64'(exp_b.size()), 64'd0);

    // 3x1 screen on 4 engines: priming stops early, slot 3 never valid
    for (int k = 0; k < 3; k++) push(2, k, k, 0);
    bus_c.start = 1'b1;
    @(negedge clk);
    bus_c.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("short_valid", 64'(bus_c.pixel_valid), 64'h7);
    chk("short_state", 64'(st_c), 64'd2);
    repeat (3) @(negedge clk);
    chk("short_hold_valid", 64'(bus_c.pixel_valid), 64'h7);
    chk("short_no_fd", 64'(fd_cnt[2]), 64'd0);
    bus_c.engine_ready = 4'b1111;
    cnt = 0;
    while (!bus_c.frame_done && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("short_fd_cycles", 64'(cnt), 64'd4);
    chk("short_end_valid", 64'(bus_c.pixel_valid), 64'd0);
    bus_c.engine_ready = '0;

`ifdef DISTRIBUTOR_PAUSE_EN
    // Pause after slot 1 holds priming, release resumes at (2,0)
    do_reset();
    for (int k = 0; k < 4; k++) push(0, k, k, 0);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pause_pre_valid", 64'(bus_a.pixel_valid), 64'h3);
    pause = 1'b1;
    repeat (3) @(negedge clk);
    chk("pause_valid", 64'(bus_a.pixel_valid), 64'h3);
    chk("pause_state", 64'(st_a), 64'd1);
    pause = 1'b0;
    repeat (2) @(negedge clk);
    chk("pause_resume_valid", 64'(bus_a.pixel_valid), 64'hf);
    chk("pause_x2", 64'(slot(bus_a.x0_out, 2)), 64'd2);
`endif

    repeat (3) @(negedge clk);
    chk("final_a_drained", 64'(exp_a.size()), 64'd0);
    chk("final_c_drained", 64'(exp_c.size()), 64'd0);
    chk("fd_count_a", 64'(fd_cnt[0]), 64'd0);
    chk("fd_count_b", 64'(fd_cnt[1]), 64'd1);
    chk("fd_count_c", 64'(fd_cnt[2]), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
